// File: rtl/ring_decoder_checker.sv
// One-hot ring-counter decoder with a lock/flywheel sequence checker.
// Decodes the set-bit position of each valid sample and tracks lock state and error statistics.
module ring_decoder_checker #(
    parameter int unsigned LOCK_CNT  = 3,
    parameter int unsigned ERR_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  ring_in,
    input  logic        in_valid,
    output logic [2:0]  index,
    output logic        index_valid,
    output logic        locked,
    output logic        err_onehot,
    output logic        err_seq,
    output logic [7:0]  err_count,
    output logic        wrap,
    output logic [15:0] wrap_count
);

    localparam int unsigned GW = ($clog2(LOCK_CNT + 1) < 1) ? 1 : $clog2(LOCK_CNT + 1);
    localparam int unsigned BW = ($clog2(ERR_LIMIT + 1) < 1) ? 1 : $clog2(ERR_LIMIT + 1);

    typedef enum logic [1:0] {
        SEARCH,
        LOCKING,
        LOCKED
    } state_t;

    state_t          state;
    logic [2:0]      exp_idx;
    logic [GW-1:0]   good_cnt;
    logic [BW-1:0]   bad_cnt;
    logic            is_onehot;
    logic [2:0]      dec_idx;

    always_comb begin
        is_onehot = $onehot(ring_in);
        dec_idx   = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (ring_in[i]) dec_idx = 3'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= SEARCH;
            exp_idx     <= '0;
            good_cnt    <= '0;
            bad_cnt     <= '0;
            index       <= '0;
            index_valid <= 1'b0;
            locked      <= 1'b0;
            err_onehot  <= 1'b0;
            err_seq     <= 1'b0;
            err_count   <= '0;
            wrap        <= 1'b0;
            wrap_count  <= '0;
        end else begin
            err_onehot <= 1'b0;
            err_seq    <= 1'b0;
            wrap       <= 1'b0;
            if (in_valid) begin
                index_valid <= is_onehot;
                if (is_onehot) index <= dec_idx;
                case (state)
                    SEARCH: begin
                        if (is_onehot) begin
                            state    <= LOCKING;
                            exp_idx  <= dec_idx + 3'd1;
                            good_cnt <= '0;
                        end
                    end
                    LOCKING: begin
                        if (!is_onehot) begin
                            state    <= SEARCH;
                            good_cnt <= '0;
                        end else if (dec_idx == exp_idx) begin
                            exp_idx <= exp_idx + 3'd1;
                            // good_cnt holds successes so far; this sample is the LOCK_CNT-th one
                            if (good_cnt == GW'(LOCK_CNT - 1)) begin
                                state    <= LOCKED;
                                locked   <= 1'b1;
                                bad_cnt  <= '0;
                                good_cnt <= '0;
                            end else begin
                                good_cnt <= good_cnt + 1'b1;
                            end
                        end else begin
                            exp_idx  <= dec_idx + 3'd1;
                            good_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        // Flywheel: the expected position advances whether or not the sample matched
                        exp_idx <= exp_idx + 3'd1;
                        if (is_onehot && (dec_idx == exp_idx)) begin
                            bad_cnt <= '0;
                            if (dec_idx == 3'd0) begin
                                wrap       <= 1'b1;
                                wrap_count <= wrap_count + 16'd1;
                            end
                        end else begin
                            err_onehot <= !is_onehot;
                            err_seq    <= is_onehot;
                            if (err_count != '1) err_count <= err_count + 8'd1;
                            if (bad_cnt == BW'(ERR_LIMIT - 1)) begin
                                state   <= SEARCH;
                                locked  <= 1'b0;
                                bad_cnt <= '0;
                            end else begin
                                bad_cnt <= bad_cnt + 1'b1;
                            end
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ring_decoder_checker.sv
// Directed bench for ring_decoder_checker with hand-computed expectations.
module tb_ring_decoder_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  ring_in = '0;
    logic        in_valid = 1'b0;
    logic [2:0]  index;
    logic        index_valid;
    logic        locked;
    logic        err_onehot;
    logic        err_seq;
    logic [7:0]  err_count;
    logic        wrap;
    logic [15:0] wrap_count;
    logic [4:0]  flags;

    int checks = 0;
    int errors = 0;
    int e;

    ring_decoder_checker #(.LOCK_CNT(3), .ERR_LIMIT(4)) dut (
        .clk(clk), .reset(reset), .ring_in(ring_in), .in_valid(in_valid),
        .index(index), .index_valid(index_valid), .locked(locked),
        .err_onehot(err_onehot), .err_seq(err_seq), .err_count(err_count),
        .wrap(wrap), .wrap_count(wrap_count)
    );

    always #5 clk = ~clk;

    // {locked, index_valid, err_onehot, err_seq, wrap}
    assign flags = {locked, index_valid, err_onehot, err_seq, wrap};

    task automatic send(input logic [7:0] v);
        ring_in  = v;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        ring_in  = 8'hFF;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b1;
        ring_in  = 8'h01;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; ring_in = 8'h01;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0; in_valid = 1'b0;
        checks++; if (flags !== 5'b00000) begin errors++; $display("FAIL reset_flags got=%b exp=00000", flags); end
        checks++; if (index !== 3'd0) begin errors++; $display("FAIL reset_index got=%0d exp=0", index); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
        checks++; if (wrap_count !== 16'd0) begin errors++; $display("FAIL reset_wrap_count got=%0d exp=0", wrap_count); end
    endtask

    task automatic test_lock();
        logic [7:0] vals [4] = '{8'h01, 8'h02, 8'h04, 8'h08};
        logic [4:0] expf [4] = '{5'b01000, 5'b01000, 5'b01000, 5'b11000};
        for (int i = 0; i < 4; i++) begin
            send(vals[i]);
            checks++; if (flags !== expf[i]) begin errors++; $display("FAIL lock_flags[%0d] got=%b exp=%b", i, flags, expf[i]); end
            checks++; if (index !== 3'(i)) begin errors++; $display("FAIL lock_index[%0d] got=%0d exp=%0d", i, index, i); end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] v;
        for (int i = 4; i < 8; i++) begin
            v = 8'h01 << i;
            send(v);
            checks++; if (flags !== 5'b11000 || index !== 3'(i)) begin errors++; $display("FAIL rot[%0d] flags=%b index=%0d exp=11000/%0d", i, flags, index, i); end
        end
        send(8'h01);
        checks++; if (flags !== 5'b11001) begin errors++; $display("FAIL wrap_flags got=%b exp=11001", flags); end
        checks++; if (wrap_count !== 16'd1) begin errors++; $display("FAIL wrap_count1 got=%0d exp=1", wrap_count); end
        send(8'h02);
        checks++; if (flags !== 5'b11000) begin errors++; $display("FAIL wrap_pulse_len got=%b exp=11000", flags); end
        for (int k = 0; k < 128; k++) begin
            v = 8'h01 << ((k + 2) % 8);
            send(v);
        end
        checks++; if (wrap_count !== 16'd17) begin errors++; $display("FAIL wrap_count17 got=%0d exp=17", wrap_count); end
        checks++; if (flags !== 5'b11000 || index !== 3'd1) begin errors++; $display("FAIL after_rot flags=%b index=%0d exp=11000/1", flags, index); end
    endtask

    task automatic test_onehot_err();
        send(8'h00);
        checks++; if (flags !== 5'b10100 || index !== 3'd1) begin errors++; $display("FAIL zero_err flags=%b index=%0d exp=10100/1", flags, index); end
        checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL zero_err_count got=%0d exp=1", err_count); end
        send(8'h03);
        checks++; if (flags !== 5'b10100 || index !== 3'd1) begin errors++; $display("FAIL multi_err flags=%b index=%0d exp=10100/1", flags, index); end
        checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL multi_err_count got=%0d exp=2", err_count); end
        // expected position advanced past 2 and 3, so 4 is the flywheel-correct sample
        send(8'h10);
        checks++; if (flags !== 5'b11000 || index !== 3'd4) begin errors++; $display("FAIL flywheel_good flags=%b index=%0d exp=11000/4", flags, index); end
        for (int i = 0; i < 3; i++) begin
            send(8'h01);
            checks++; if (flags !== 5'b11010) begin errors++; $display("FAIL badcnt_clear[%0d] flags=%b exp=11010", i, flags); end
            checks++; if (err_count !== 8'(3 + i)) begin errors++; $display("FAIL badcnt_clear_count[%0d] got=%0d exp=%0d", i, err_count, 3 + i); end
        end
        send(8'h01);
        checks++; if (flags !== 5'b11001 || wrap_count !== 16'd18) begin errors++; $display("FAIL flywheel_wrap flags=%b wc=%0d exp=11001/18", flags, wrap_count); end
    endtask

    task automatic test_seq_err();
        logic [4:0] expf [4] = '{5'b11010, 5'b11010, 5'b11010, 5'b01010};
        logic [7:0] rel [4] = '{8'h02, 8'h04, 8'h08, 8'h10};
        for (int i = 0; i < 4; i++) begin
            send(8'h01);
            checks++; if (flags !== expf[i]) begin errors++; $display("FAIL seq_err[%0d] flags=%b exp=%b", i, flags, expf[i]); end
            checks++; if (err_count !== 8'(6 + i)) begin errors++; $display("FAIL seq_err_count[%0d] got=%0d exp=%0d", i, err_count, 6 + i); end
        end
        for (int i = 0; i < 4; i++) begin
            send(rel[i]);
            checks++; if (locked !== (i == 3)) begin errors++; $display("FAIL relock[%0d] locked=%b exp=%b", i, locked, i == 3); end
        end
        idle(3);
        checks++; if (flags !== 5'b11000 || index !== 3'd4 || err_count !== 8'd9) begin errors++; $display("FAIL idle_hold flags=%b index=%0d ec=%0d exp=11000/4/9", flags, index, err_count); end
    endtask

    task automatic test_gap();
        logic [7:0] vals [9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        logic lk;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            lk = (i >= 3);
            send(vals[i]);
            checks++; if (flags !== {lk, 1'b1, 1'b0, 1'b0, (i == 8)} || index !== 3'(i % 8)) begin
                errors++; $display("FAIL gap_sample[%0d] flags=%b index=%0d exp=%b/%0d", i, flags, index, {lk, 1'b1, 1'b0, 1'b0, (i == 8)}, i % 8);
            end
            idle(i % 3 + 1);
            checks++; if (flags !== {lk, 4'b1000} || index !== 3'(i % 8)) begin
                errors++; $display("FAIL gap_hold[%0d] flags=%b index=%0d exp=%b/%0d", i, flags, index, {lk, 4'b1000}, i % 8);
            end
        end
        checks++; if (wrap_count !== 16'd1 || err_count !== 8'd0) begin errors++; $display("FAIL gap_counts wc=%0d ec=%0d exp=1/0", wrap_count, err_count); end
    endtask

    task automatic test_saturation();
        logic [7:0] v;
        e = 1;
        for (int i = 0; i < 300; i++) begin
            send(8'h00);
            e = (e + 1) % 8;
            checks++; if (err_count !== ((i + 1 > 255) ? 8'd255 : 8'(i + 1))) begin
                errors++; $display("FAIL sat_count[%0d] got=%0d exp=%0d", i, err_count, (i + 1 > 255) ? 255 : i + 1);
            end
            v = 8'h01 << e;
            send(v);
            e = (e + 1) % 8;
        end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL sat_locked got=%b exp=1", locked); end
        v = 8'h01 << e;
        reset = 1'b1; ring_in = v; in_valid = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0; in_valid = 1'b0;
        checks++; if (flags !== 5'b00000 || index !== 3'd0 || err_count !== 8'd0 || wrap_count !== 16'd0) begin
            errors++; $display("FAIL midreset flags=%b index=%0d ec=%0d wc=%0d exp=00000/0/0/0", flags, index, err_count, wrap_count);
        end
        send(8'h02);
        checks++; if (flags !== 5'b01000 || index !== 3'd1) begin errors++; $display("FAIL post_reset_search flags=%b index=%0d exp=01000/1", flags, index); end
        send(8'h04);
        send(8'h08);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL post_reset_early got=%b exp=0", locked); end
        send(8'h10);
        checks++; if (flags !== 5'b11000) begin errors++; $display("FAIL post_reset_lock flags=%b exp=11000", flags); end
    endtask

    initial begin
        #1;
        test_reset();
        test_lock();
        test_wrap();
        test_onehot_err();
        test_seq_err();
        test_gap();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ring_decoder_checker.md
RING_DECODER_CHECKER -- requirements
Module: ring_decoder_checker

Interface
REQ-001 Parameter LOCK_CNT, default 3: consecutive correct successor samples required to enter LOCKED.
REQ-002 Parameter ERR_LIMIT, default 4: consecutive bad samples in LOCKED that force return to SEARCH.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ring_in  input  8  sampled ring-counter pattern; legal values are one-hot.
REQ-006 in_valid  input  1  ring_in is sampled only on cycles where in_valid=1.
REQ-007 index  output  3  binary position of the set bit of the last valid one-hot sample.
REQ-008 index_valid  output  1  last sample was valid and one-hot.
REQ-009 locked  output  1  checker is in state LOCKED.
REQ-010 err_onehot  output  1  one-cycle pulse: LOCKED sample was not one-hot (zero or multiple bits).
REQ-011 err_seq  output  1  one-cycle pulse: LOCKED sample was one-hot but not the expected successor.
REQ-012 err_count  output  8  saturating count of LOCKED error samples.
REQ-013 wrap  output  1  one-cycle pulse: LOCKED good sample with index 0 following 7.
REQ-014 wrap_count  output  16  count of wrap pulses, modulo 2^16.

Function
REQ-015 Successor rule: bit i is followed by bit (i+1) mod 8 (rotate-left; 8'h80 followed by 8'h01).
REQ-016 All outputs are registered; response to a sample appears on the cycle after the sampling edge (latency 1).
REQ-017 in_valid=0: state, counters, index, index_valid hold; err_onehot, err_seq, wrap drive 0.
REQ-018 index and index_valid update on every valid sample in every state; a non-one-hot sample clears index_valid and leaves index unchanged.
REQ-019 States: SEARCH, LOCKING, LOCKED; internal regs exp_idx (3b), good_cnt, bad_cnt.
REQ-020 SEARCH: valid one-hot sample -> LOCKING, exp_idx = index+1 mod 8, good_cnt=0; non-one-hot -> stay SEARCH.
REQ-021 LOCKING: sample equals exp_idx -> good_cnt+1, exp_idx+1; when good_cnt reaches LOCK_CNT -> LOCKED with bad_cnt=0.
REQ-022 LOCKING: one-hot non-successor -> stay LOCKING, exp_idx reloaded from new index+1, good_cnt=0; non-one-hot -> SEARCH.
REQ-023 LOCKED: exp_idx advances by 1 on every valid sample, good or bad (flywheel).
REQ-024 LOCKED good sample: bad_cnt=0; wrap=1 and wrap_count+1 when sample index is 0.
REQ-025 LOCKED bad sample: exactly one of err_onehot/err_seq pulses, err_count+1 saturating at 255, bad_cnt+1.
REQ-026 LOCKED: bad_cnt reaching ERR_LIMIT -> SEARCH on the same edge; error pulse for that sample is still issued.
REQ-027 No error pulses or err_count changes in SEARCH or LOCKING.
REQ-028 locked asserts on the cycle after the transitioning sample and deasserts on the cycle after leaving LOCKED.

Reset
REQ-029 reset=1 at a rising edge: state SEARCH; index=0, index_valid=0, locked=0, err_onehot=0, err_seq=0, err_count=0, wrap=0, wrap_count=0; internal counters 0.
REQ-030 Reset overrides in_valid and any in-progress lock or error sequence; first sample after reset release is treated as in SEARCH.

Verification
REQ-031 Reset, then in_valid=1 with 01,02,04,08 -> locked=1 one cycle after 08; index 0,1,2,3; no error pulses.
REQ-032 Locked, continue rotation 10..80,01 -> wrap=1 for one cycle after 01, wrap_count=1; 16 further rotations -> wrap_count=17.
REQ-033 Locked, inject 8'h00 then 8'h03 -> two err_onehot pulses, err_count=2, exp_idx advanced twice, still locked; next correct-by-flywheel sample clears bad_cnt.
REQ-034 Locked, inject 4 consecutive wrong one-hot values -> 4 err_seq pulses, err_count=4, locked=0 after 4th; relock needs 1+LOCK_CNT good samples.
REQ-035 Gap test: in_valid toggles 1/0 during rotation -> lock and outputs identical to gap-free run, delayed only by gaps.
REQ-036 Saturation and mid-operation reset: 300 error samples -> err_count=255; assert reset mid-lock -> all outputs per REQ-029 next cycle.
